// File: rtl/vga_pkg.sv
// Shared VGA definitions.
// Holds the display geometry, the colour constants used by the pixel
// generator, the cursor mode encoding and a small clamp helper that both the
// cursor controller and any other bounded-motion element can use.
package vga_pkg;

  localparam int H_DISP = 640;  // active pixels per line
  localparam int V_DISP = 480;  // active lines per frame
  localparam int SIDE_W = 40;   // border width in pixels
  localparam int ARM_W  = 80;   // half-length of the cursor arms

  localparam logic [23:0] BLUE  = 24'h0000ff;
  localparam logic [23:0] WHITE = 24'hffffff;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] RED   = 24'hff0000;
  localparam logic [23:0] GREEN = 24'h00ff00;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Saturate an 11-bit position into [lo, hi].
  function automatic logic [10:0] clamp11(input logic [10:0] v,
                                          input logic [10:0] lo,
                                          input logic [10:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Free-running rate divider.
// Counts 0..DIV_CNT-1 and wraps; tick is high (combinationally) for the one
// cycle in DIV_CNT where the count sits at its last value.
// Ports:
//   vga_clk   - pixel clock
//   sys_rst_n - asynchronous active-low reset, clears the count to 0
//   tick      - one-cycle strobe every DIV_CNT cycles
module vga_tick_div #(
  parameter int DIV_CNT = 250000
) (
  input  logic vga_clk,
  input  logic sys_rst_n,
  output logic tick
);

  localparam int CW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_CNT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)         count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/vga_cursor_ctrl.sv
// Cursor position scheduler for the cross-shaped VGA cursor.
// Motion is rate-limited by a tick divider and computed on a shadow position;
// the shadow is copied to the drawn position only at end-of-frame so the
// renderer never sees a position change mid-frame. Two modes: manual (four
// direction buttons) and auto-bounce (reflects off the inner border). The
// mode itself only switches at end-of-frame.
// Ports:
//   vga_clk, sys_rst_n        - pixel clock, async active-low reset
//   pixel_xpos, pixel_ypos    - current scan position from the VGA driver
//   btn_up/down/left/right    - debounced level requests (manual mode)
//   mode_auto                 - requested mode, 1 = auto-bounce
//   cur_x, cur_y              - committed cursor centre
//   auto_active               - committed mode (the FSM state)
//   h_direct, v_direct        - auto directions, 1 = right / down
//   frame_commit              - pulse the cycle after cur_x/cur_y load
module vga_cursor_ctrl #(
  parameter int H_DISP  = vga_pkg::H_DISP,
  parameter int V_DISP  = vga_pkg::V_DISP,
  parameter int SIDE_W  = vga_pkg::SIDE_W,
  parameter int ARM_W   = vga_pkg::ARM_W,
  parameter int STEP    = 1,
  parameter int DIV_CNT = 250000,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] pixel_xpos,
  input  logic [9:0] pixel_ypos,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       mode_auto,
  output logic [9:0] cur_x,
  output logic [9:0] cur_y,
  output logic       auto_active,
  output logic       h_direct,
  output logic       v_direct,
  output logic       frame_commit
);

  import vga_pkg::*;

  localparam logic [10:0] X_MIN  = 11'(SIDE_W + ARM_W);
  localparam logic [10:0] X_MAX  = 11'(H_DISP - SIDE_W - ARM_W);
  localparam logic [10:0] Y_MIN  = 11'(SIDE_W + ARM_W);
  localparam logic [10:0] Y_MAX  = 11'(V_DISP - SIDE_W - ARM_W);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [9:0]  X_LAST = 10'(H_DISP - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_DISP - 1);

  logic        move_tick;
  logic        frame_end;
  mode_e       state, state_nxt;
  logic [9:0]  sh_x, sh_y, sh_x_nxt, sh_y_nxt;
  logic        h_nxt, v_nxt;
  logic [10:0] x_inc, x_dec, y_inc, y_dec;
  logic [10:0] x_res, y_res;

  vga_tick_div #(
    .DIV_CNT (DIV_CNT)
  ) u_tick_div (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .tick      (move_tick)
  );

  assign frame_end = (pixel_xpos == X_LAST) && (pixel_ypos == Y_LAST);

  // Shadow stays in [MIN, MAX], so 11-bit +/- STEP never wraps.
  assign x_inc = {1'b0, sh_x} + STEP11;
  assign x_dec = {1'b0, sh_x} - STEP11;
  assign y_inc = {1'b0, sh_y} + STEP11;
  assign y_dec = {1'b0, sh_y} - STEP11;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= MODE_MANUAL;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    x_res     = {1'b0, sh_x};
    y_res     = {1'b0, sh_y};
    h_nxt     = h_direct;
    v_nxt     = v_direct;
    case (state)
      MODE_MANUAL: begin
        if (frame_end && mode_auto) state_nxt = MODE_AUTO;
        if (move_tick) begin
          // Opposing buttons cancel and leave the axis where it is.
          if (btn_left && !btn_right)      x_res = clamp11(x_dec, X_MIN, X_MAX);
          else if (btn_right && !btn_left) x_res = clamp11(x_inc, X_MIN, X_MAX);
          if (btn_up && !btn_down)         y_res = clamp11(y_dec, Y_MIN, Y_MAX);
          else if (btn_down && !btn_up)    y_res = clamp11(y_inc, Y_MIN, Y_MAX);
        end
      end
      MODE_AUTO: begin
        if (frame_end && !mode_auto) state_nxt = MODE_MANUAL;
        if (move_tick) begin
          // Landing exactly on a bound counts as a hit: park there and flip.
          if (h_direct) begin
            if (x_inc >= X_MAX) begin x_res = X_MAX; h_nxt = 1'b0; end
            else                      x_res = x_inc;
          end else begin
            if (x_dec <= X_MIN) begin x_res = X_MIN; h_nxt = 1'b1; end
            else                      x_res = x_dec;
          end
          if (v_direct) begin
            if (y_inc >= Y_MAX) begin y_res = Y_MAX; v_nxt = 1'b0; end
            else                      y_res = y_inc;
          end else begin
            if (y_dec <= Y_MIN) begin y_res = Y_MIN; v_nxt = 1'b1; end
            else                      y_res = y_dec;
          end
        end
      end
      default: state_nxt = MODE_MANUAL;
    endcase
    sh_x_nxt = x_res[9:0];
    sh_y_nxt = y_res[9:0];
  end

  // Commit samples the pre-update shadow, so a tick landing on frame_end
  // shows up one frame later.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sh_x         <= 10'(X_INIT);
      sh_y         <= 10'(Y_INIT);
      cur_x        <= 10'(X_INIT);
      cur_y        <= 10'(Y_INIT);
      h_direct     <= 1'b1;
      v_direct     <= 1'b1;
      frame_commit <= 1'b0;
    end else begin
      sh_x         <= sh_x_nxt;
      sh_y         <= sh_y_nxt;
      h_direct     <= h_nxt;
      v_direct     <= v_nxt;
      frame_commit <= frame_end;
      if (frame_end) begin
        cur_x <= sh_x;
        cur_y <= sh_y;
      end
    end
  end

  assign auto_active = (state == MODE_AUTO);

endmodule

// File: tb/tb_vga_cursor_ctrl.sv
// Self-checking bench for vga_cursor_ctrl (STEP=4, DIV_CNT=4, default
// geometry: x bounds 120..520, y bounds 120..360).
// Rows are aligned to the 4-cycle divider: each row holds its inputs for
// n_ticks ticks, then a 4-cycle commit block drives frame_end on its first
// cycle with buttons released (the block's own tick runs in the new mode).
module tb_vga_cursor_ctrl;

  logic       vga_clk;
  logic       sys_rst_n;
  logic [9:0] pixel_xpos, pixel_ypos;
  logic       btn_up, btn_down, btn_left, btn_right, mode_auto;
  logic [9:0] cur_x, cur_y;
  logic       auto_active, h_direct, v_direct, frame_commit;

  int n_checks = 0;
  int n_errors = 0;

  logic [19:0] exp_q[$];

  typedef struct {
    logic       mode;
    logic       up, down, left, right;
    int         n_ticks;
    logic [9:0] ex, ey;      // shadow committed at this row's frame_end
    logic       ea, eh, ev;  // auto_active / h / v after the commit block
  } vec_t;

  vec_t vecs[9];

  vga_cursor_ctrl #(
    .STEP    (4),
    .DIV_CNT (4)
  ) dut (
    .vga_clk      (vga_clk),
    .sys_rst_n    (sys_rst_n),
    .pixel_xpos   (pixel_xpos),
    .pixel_ypos   (pixel_ypos),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .mode_auto    (mode_auto),
    .cur_x        (cur_x),
    .cur_y        (cur_y),
    .auto_active  (auto_active),
    .h_direct     (h_direct),
    .v_direct     (v_direct),
    .frame_commit (frame_commit)
  );

  // clock / reset
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every frame_commit pulse must match one queued frame_end.
  always @(negedge vga_clk) begin
    if (frame_commit) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL commit_spurious: got pulse with cur=(%0d,%0d) expected none",
                 cur_x, cur_y);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("commit_x", int'(cur_x), int'(e[19:10]));
        check("commit_y", int'(cur_y), int'(e[9:0]));
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  task automatic frame_end_cycle(input logic push, input logic [9:0] ex, input logic [9:0] ey);
    pixel_xpos = 10'd639;
    pixel_ypos = 10'd479;
    if (push) exp_q.push_back({ex, ey});
    step(1);
    pixel_xpos = 10'd0;
    pixel_ypos = 10'd0;
  endtask

  initial begin
    logic [9:0] prev_x, prev_y;
    logic       prev_a;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10,  10'd360, 10'd240, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 61,  10'd120, 10'd240, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5,   10'd120, 10'd240, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40,  10'd120, 10'd360, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2,   10'd128, 10'd360, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 100, 10'd508, 10'd280, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,   10'd504, 10'd284, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3,   10'd516, 10'd272, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,   10'd516, 10'd272, 1'b1, 1'b0, 1'b1};

    sys_rst_n  = 1'b0;
    pixel_xpos = 10'd0;
    pixel_ypos = 10'd0;
    mode_auto  = 1'b0;
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge vga_clk);
    #1;
    check("rst_cur_x", int'(cur_x), 320);
    check("rst_cur_y", int'(cur_y), 240);
    check("rst_fc", int'(frame_commit), 0);
    sys_rst_n = 1'b1;

    prev_x = 10'd320;
    prev_y = 10'd240;
    prev_a = 1'b0;

    for (int i = 0; i < 9; i++) begin
      mode_auto = vecs[i].mode;
      set_btn(vecs[i].up, vecs[i].down, vecs[i].left, vecs[i].right);
      step(4 * vecs[i].n_ticks);
      // nothing may reach the drawn position or the mode before frame_end
      check($sformatf("row%0d_pre_x", i), int'(cur_x), int'(prev_x));
      check($sformatf("row%0d_pre_y", i), int'(cur_y), int'(prev_y));
      check($sformatf("row%0d_pre_auto", i), int'(auto_active), int'(prev_a));
      set_btn(1'b0, 1'b0, 1'b0, 1'b0);
      frame_end_cycle(1'b1, vecs[i].ex, vecs[i].ey);
      step(3);
      check($sformatf("row%0d_x", i), int'(cur_x), int'(vecs[i].ex));
      check($sformatf("row%0d_y", i), int'(cur_y), int'(vecs[i].ey));
      check($sformatf("row%0d_auto", i), int'(auto_active), int'(vecs[i].ea));
      check($sformatf("row%0d_h", i), int'(h_direct), int'(vecs[i].eh));
      check($sformatf("row%0d_v", i), int'(v_direct), int'(vecs[i].ev));
      prev_x = vecs[i].ex;
      prev_y = vecs[i].ey;
      prev_a = vecs[i].ea;
    end

    // Asynchronous reset landing inside a commit pulse, in AUTO with h=0.
    frame_end_cycle(1'b0, 10'd0, 10'd0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_cur_x", int'(cur_x), 320);
    check("async_cur_y", int'(cur_y), 240);
    check("async_auto", int'(auto_active), 0);
    check("async_h", int'(h_direct), 1);
    check("async_v", int'(v_direct), 1);
    check("async_fc", int'(frame_commit), 0);
    mode_auto = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    sys_rst_n = 1'b1;

    // frame_end on the tick cycle: commit takes 320, shadow moves to 324.
    set_btn(1'b0, 1'b0, 1'b0, 1'b1);
    step(3);
    frame_end_cycle(1'b1, 10'd320, 10'd240);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    check("coinc_first_x", int'(cur_x), 320);
    step(3);
    check("coinc_hold_x", int'(cur_x), 320);
    step(1);
    frame_end_cycle(1'b1, 10'd324, 10'd240);
    check("coinc_next_x", int'(cur_x), 324);
    step(3);

    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
